fetcher: RTL
============

# fetcher

Instruction fetch stage: drives the PC, issues one-at-a-time requests to the instruction cache, and predecodes each returned word. For conditional branches it consults the 2-bit branch predictor with a PC-derived tag. It buffers fetched instructions, with their PC and prediction bit, in an in-order instruction queue feeding the decoder/dispatcher. A ROB flush redirects it.

## Interface
- IQ_DEPTH, 16, instruction-queue entries (power of two)
- BP_TAG_BITS, 8, predictor tag width; tag = pc[BP_TAG_BITS+1:2]
- RESET_PC, 32'h0, first fetch address
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state, outputs hold
- out_icache_ce  out  1  one-cycle request pulse
- out_icache_pc  out  32  request address, valid while ce high
- in_icache_valid  in  1  one-cycle response pulse
- in_icache_inst  in  32  response word, valid with in_icache_valid
- out_bp_tag  out  BP_TAG_BITS  predictor index, combinational from in-flight PC
- in_bp_jump  in  1  predictor result (counter MSB), combinational, same cycle
- out_dispatch_valid  out  1  queue non-empty
- in_dispatch_ready  in  1  consumer accepts head this cycle
- out_dispatch_inst / out_dispatch_pc  out  32 / 32  head word / its PC
- out_dispatch_pred_jump  out  1  head predicted taken
- in_rob_flush  in  1  misprediction redirect
- in_rob_target_pc  in  32  redirect PC

## Operation
- FSM states: IDLE, WAIT, DISCARD.
- IDLE: if queue count < IQ_DEPTH, pulse ce with pc = fetch_pc and go to WAIT. Otherwise stay.
- WAIT: on in_icache_valid, push {inst, fetch_pc, pred} to the queue, load fetch_pc <= next_pc, and go to IDLE.
- Predecode, opcode = inst[6:0]:
  - 1101111 JAL: next = pc + J-imm, pred=1.
  - 1100011 branch: pred = in_bp_jump; next = pred ? pc + B-imm : pc + 4.
  - JALR and all others: next = pc + 4, pred=0.
- J-imm = sext{i[31],i[19:12],i[20],i[30:21],0}. B-imm = sext{i[31],i[7],i[30:25],i[11:8],0}. All adds are mod 2^32.
- Queue: circular FIFO, head/tail wrap at IQ_DEPTH. Pop when out_dispatch_valid & in_dispatch_ready. Push and pop in the same cycle keep the count unchanged.
- in_rob_flush, highest priority, any state:
  - Clear the queue (count=0, head=tail).
  - Set fetch_pc <= in_rob_target_pc.
  - If a request is outstanding (WAIT without valid this cycle), go to DISCARD; else go to IDLE.
  - Any pop in the same cycle is ignored (the consumer also flushes).
- Flush coinciding with in_icache_valid: the response is dropped, no push, go to IDLE.
- DISCARD: wait for in_icache_valid, drop the word, go to IDLE. A further flush here only updates fetch_pc.
- Only one request is ever outstanding, so a request issued at count < IQ_DEPTH can always be pushed.

## Timing
- Reset values: state IDLE, fetch_pc=RESET_PC, queue empty, out_icache_ce=0, out_dispatch_valid=0, pred/inst/pc outputs 0.
- ce/pc are registered. The first pulse appears in the cycle after rst deasserts (if rdy is high).
- Response at edge m: the entry is visible on dispatch from cycle m+1, and the next ce pulse occurs in cycle m+2.
- Dispatch outputs are registered from queue storage. The head updates the cycle after a pop.
- rdy low: no state change. An in_icache_valid arriving while rdy is low is not the fetcher's responsibility; the cache holds it.

## Structure
- Shared constants go in constant.v: opcode values (JAL, BRANCH, JALR), `TRUE/`FALSE, IQ_DEPTH, BP_TAG_BITS.
- Sub-module inst_queue: parameterised FIFO with push, pop, flush, full and empty. The fetcher holds the FSM, PC and predecode.

## Test plan
- Reset, then icache returns 32'h00000013 (addi) after 2 cycles. Required: ce at pc 0, entry {inst 0x13, pc 0, pred 0}, next request pc 4.
- JAL with imm +16 at pc 0x100 -> pred=1, next request pc 0x110.
- Branch imm −8 at pc 0x200, with bp_jump=1 then 0. Required: next pc 0x1F8 with pred=1, then 0x204 with pred=0. out_bp_tag = 0x80 in both cases.
- in_dispatch_ready held 0 -> exactly IQ_DEPTH entries pushed, then no further ce. Raise ready for 1 cycle -> one pop, one new request.
- Flush to 0x400 while WAIT -> queue empty next cycle, the late response is dropped, next ce pc = 0x400.
- Flush in the same cycle as in_icache_valid -> no push, state IDLE, next ce pc = target.

Source files
------------

// File: rtl/fetcher_pkg.sv
// Shared constants, types and the predecode helper for the instruction fetch stage.
package fetcher_pkg;

    localparam int DEFAULT_IQ_DEPTH    = 16;
    localparam int DEFAULT_BP_TAG_BITS = 8;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    typedef struct packed {
        logic [31:0] next_pc;
        logic        pred;
    } predecode_t;

    localparam int IQ_ENTRY_BITS = $bits(iq_entry_t);

    // Only JAL and conditional branches redirect; JALR needs a register value and falls through.
    function automatic predecode_t predecode(input logic [31:0] pc,
                                             input logic [31:0] inst,
                                             input logic        bp_jump);
        predecode_t  res;
        logic [31:0] j_imm;
        logic [31:0] b_imm;
        j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        res.next_pc = pc + 32'd4;
        res.pred    = FALSE;
        case (inst[6:0])
            OPC_JAL: begin
                res.next_pc = pc + j_imm;
                res.pred    = TRUE;
            end
            OPC_BRANCH: begin
                res.pred = bp_jump;
                if (bp_jump) begin
                    res.next_pc = pc + b_imm;
                end
            end
            OPC_JALR: begin
                res.next_pc = pc + 32'd4;
            end
            default: begin
                res.next_pc = pc + 32'd4;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fetcher_inst_queue.sv
// In-order circular instruction queue; the head entry is held in a register so the
// dispatch outputs come straight from flops.
module fetcher_inst_queue
    import fetcher_pkg::*;
#(
    parameter int DEPTH = DEFAULT_IQ_DEPTH,
    parameter int WIDTH = IQ_ENTRY_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW-1:0]    head_nxt;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        head_nxt  = head + AW'(do_pop);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (en && !flush && do_push) begin
            mem[tail] <= push_data;
        end
    end

    // A push landing where the new head points bypasses storage so it is visible next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            head_data <= '0;
        end else if (en) begin
            if (flush) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                head_data <= '0;
            end else begin
                if (do_push) begin
                    tail <= tail + PTR_ONE;
                end
                head  <= head_nxt;
                count <= count_nxt;
                if (do_push && head_nxt == tail) begin
                    head_data <= push_data;
                end else begin
                    head_data <= mem[head_nxt];
                end
            end
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: PC sequencing, single-outstanding icache requests,
// branch predecode and the instruction queue towards dispatch.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH    = DEFAULT_IQ_DEPTH,
    parameter int          BP_TAG_BITS = DEFAULT_BP_TAG_BITS,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    output logic                   out_icache_ce,
    output logic [31:0]            out_icache_pc,
    input  logic                   in_icache_valid,
    input  logic [31:0]            in_icache_inst,
    output logic [BP_TAG_BITS-1:0] out_bp_tag,
    input  logic                   in_bp_jump,
    output logic                   out_dispatch_valid,
    input  logic                   in_dispatch_ready,
    output logic [31:0]            out_dispatch_inst,
    output logic [31:0]            out_dispatch_pc,
    output logic                   out_dispatch_pred_jump,
    input  logic                   in_rob_flush,
    input  logic [31:0]            in_rob_target_pc
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    predecode_t   pd;
    iq_entry_t    push_entry;
    iq_entry_t    head_entry;
    logic         iq_push;
    logic         iq_pop;
    logic         iq_full;
    logic         iq_empty;

    assign out_bp_tag = fetch_pc[BP_TAG_BITS+1:2];

    always_comb begin
        pd         = predecode(fetch_pc, in_icache_inst, in_bp_jump);
        push_entry = '{inst: in_icache_inst, pc: fetch_pc, pred: pd.pred};
        iq_push    = (state == S_WAIT) && in_icache_valid && !in_rob_flush;
        iq_pop     = in_dispatch_ready && !iq_empty;
    end

    fetcher_inst_queue #(
        .DEPTH(IQ_DEPTH),
        .WIDTH(IQ_ENTRY_BITS)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .flush    (in_rob_flush),
        .push     (iq_push),
        .push_data(push_entry),
        .pop      (iq_pop),
        .head_data(head_entry),
        .full     (iq_full),
        .empty    (iq_empty)
    );

    assign out_dispatch_valid     = !iq_empty;
    assign out_dispatch_inst      = head_entry.inst;
    assign out_dispatch_pc        = head_entry.pc;
    assign out_dispatch_pred_jump = head_entry.pred;

    // A redirect during an outstanding request must swallow the stale response in DISCARD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            fetch_pc      <= RESET_PC;
            out_icache_ce <= FALSE;
            out_icache_pc <= '0;
        end else if (rdy) begin
            out_icache_ce <= FALSE;
            if (in_rob_flush) begin
                fetch_pc <= in_rob_target_pc;
                state    <= (state != S_IDLE && !in_icache_valid) ? S_DISCARD : S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!iq_full) begin
                            out_icache_ce <= TRUE;
                            out_icache_pc <= fetch_pc;
                            state         <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (in_icache_valid) begin
                            fetch_pc <= pd.next_pc;
                            state    <= S_IDLE;
                        end
                    end
                    S_DISCARD: begin
                        if (in_icache_valid) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
